instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_skid_buf.sv | 41 ++++
 rtl/instruction_fetch_unit.sv | 109 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, the NOP encoding and the fetch FSM state type for the
// instruction fetch front end.
package cpu_pkg;
  localparam int          IMEM_ADDR_W = 6;
  localparam int          INST_W      = 32;
  localparam logic [31:0] NOP_INST    = 32'h0007_8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HELD = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer: parks the word returning from memory while the
// output stage is frozen, so nothing in flight is lost.
module fetch_skid_buf
  import cpu_pkg::*;
#(
  parameter int DATA_W = INST_W,
  parameter int PC_W   = IMEM_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  input  logic [PC_W-1:0]   i_pc,
  output logic [DATA_W-1:0] o_data,
  output logic [PC_W-1:0]   o_pc,
  output logic              o_valid
);
  logic [DATA_W-1:0] r_data;
  logic [PC_W-1:0]   r_pc;
  logic              r_valid;

  // Clear wins over load so a flush can never leave a stale entry behind.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data  <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetch from a one-cycle-latency memory with stall
// freezing, a one-entry skid buffer and redirect flush.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                IMEM_ADDR_W = cpu_pkg::IMEM_ADDR_W,
  parameter int                INST_W      = cpu_pkg::INST_W,
  parameter logic [INST_W-1:0] NOP_INST    = cpu_pkg::NOP_INST
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [IMEM_ADDR_W-1:0] redirect_addr,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0]      imem_data,
  output logic [INST_W-1:0]      inst_out,
  output logic [IMEM_ADDR_W-1:0] inst_pc,
  output logic                   inst_valid,
  output fetch_state_t           dbg_state
);
  fetch_state_t           r_state, w_state_nxt;
  logic [IMEM_ADDR_W-1:0] r_pc_f, r_req_pc, r_inst_pc;
  logic                   r_req_v, r_inst_valid;
  logic [INST_W-1:0]      r_inst_out;
  logic                   w_issue;
  logic [INST_W-1:0]      w_skid_data;
  logic [IMEM_ADDR_W-1:0] w_skid_pc;
  logic                   w_skid_v;

  // Handshake: stall is the consumer's not-ready. With stall=0 the output
  // stage is taken every cycle (inst_valid qualifies inst_out/inst_pc); with
  // stall=1 every visible output and pc_f hold until stall drops.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = RUN;
      RUN:     if (stall)  w_state_nxt = HELD;
      HELD:    if (!stall) w_state_nxt = RUN;
      default:             w_state_nxt = IDLE;
    endcase
    if (redirect_valid) w_state_nxt = (r_state == IDLE) ? IDLE : RUN;
    // The start cycle itself issues, and HELD issues on release, so the
    // pipe refills without a bubble.
    w_issue = !stall && !redirect_valid && ((r_state != IDLE) || start);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pc_f       <= '0;
      r_req_v      <= 1'b0;
      r_req_pc     <= '0;
      r_inst_out   <= NOP_INST;
      r_inst_pc    <= '0;
      r_inst_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid) begin
        r_pc_f       <= redirect_addr;
        r_req_v      <= 1'b0;
        r_inst_out   <= NOP_INST;
        r_inst_valid <= 1'b0;
      end else begin
        r_req_v <= w_issue;
        if (w_issue) begin
          r_req_pc <= r_pc_f;
          r_pc_f   <= r_pc_f + 1'b1;
        end
        if (!stall) begin
          if (w_skid_v) begin
            r_inst_out   <= w_skid_data;
            r_inst_pc    <= w_skid_pc;
            r_inst_valid <= 1'b1;
          end else if (r_req_v) begin
            r_inst_out   <= imem_data;
            r_inst_pc    <= r_req_pc;
            r_inst_valid <= 1'b1;
          end else begin
            r_inst_out   <= NOP_INST;
            r_inst_valid <= 1'b0;
          end
        end
      end
    end
  end

  fetch_skid_buf #(
    .DATA_W (INST_W),
    .PC_W   (IMEM_ADDR_W)
  ) u_skid (
    .i_clk   (clk),
    .i_reset (reset),
    .i_load  (stall && r_req_v && !redirect_valid),
    .i_clear (redirect_valid || !stall),
    .i_data  (imem_data),
    .i_pc    (r_req_pc),
    .o_data  (w_skid_data),
    .o_pc    (w_skid_pc),
    .o_valid (w_skid_v)
  );

  assign imem_addr  = r_pc_f;
  assign inst_out   = r_inst_out;
  assign inst_pc    = r_inst_pc;
  assign inst_valid = r_inst_valid;
  assign dbg_state  = r_state;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, hand-written
// corner sequences and random traffic against a queue-based fetch model.
module tb_instruction_fetch_unit;
  import cpu_pkg::*;

  localparam int          AW  = cpu_pkg::IMEM_ADDR_W;
  localparam int          DW  = cpu_pkg::INST_W;
  localparam logic [31:0] NOP = cpu_pkg::NOP_INST;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1, start = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic [DW-1:0] inst_out;
  logic [AW-1:0] inst_pc;
  logic          inst_valid;
  fetch_state_t  dbg_state;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .dbg_state      (dbg_state)
  );

  // Synchronous instruction memory: data one cycle after the address.
  logic [DW-1:0] mem [64];
  always @(posedge clk) imem_data <= mem[imem_addr];

  // ---------------- reference model ----------------
  // Fetched-but-not-delivered addresses in program order; the front entry
  // is what the next unstalled cycle must present.
  logic [AW-1:0] exp_q[$];
  bit            m_active;
  logic [AW-1:0] m_pc;
  bit            m_valid;
  logic [AW-1:0] m_out_pc;
  logic [DW-1:0] m_out_data;

  task automatic model_step(input bit rst, input bit st, input bit sl,
                            input bit rd, input logic [AW-1:0] ra);
    if (rst) begin
      m_active = 0; m_pc = '0; exp_q.delete();
      m_valid = 0; m_out_pc = '0; m_out_data = NOP;
    end else if (rd) begin
      m_pc = ra; exp_q.delete(); m_valid = 0; m_out_data = NOP;
    end else begin
      if (!sl) begin
        if (exp_q.size() > 0) begin
          m_out_pc = exp_q.pop_front(); m_valid = 1; m_out_data = mem[m_out_pc];
        end else begin
          m_valid = 0; m_out_data = NOP;
        end
        if (m_active || st) begin
          exp_q.push_back(m_pc);
          m_pc = (m_pc + 1) % 64;
        end
      end
      m_active = m_active || st;
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit rst, input bit st, input bit sl,
                      input bit rd, input logic [AW-1:0] ra);
    @(negedge clk);
    reset = rst; start = st; stall = sl; redirect_valid = rd; redirect_addr = ra;
    @(posedge clk);
    #1;
    model_step(rst, st, sl, rd, ra);
    chk("model_valid", {31'd0, inst_valid}, {31'd0, m_valid});
    chk("model_out", inst_out, m_out_data);
    chk("model_addr", {26'd0, imem_addr}, {26'd0, m_pc});
    if (m_valid) chk("model_pc", {26'd0, inst_pc}, {26'd0, m_out_pc});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            rst, st, sl, rd;
    logic [AW-1:0] ra;
    bit            ev;
    logic [AW-1:0] epc;
    logic [AW-1:0] eaddr;
    fetch_state_t  est;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(bit rst, bit st, bit sl, bit rd, int ra,
                              bit ev, int epc, int eaddr, fetch_state_t est);
    vec_t v;
    v.rst = rst; v.st = st; v.sl = sl; v.rd = rd; v.ra = AW'(ra);
    v.ev = ev; v.epc = AW'(epc); v.eaddr = AW'(eaddr); v.est = est;
    return v;
  endfunction

  initial begin
    logic [AW-1:0] wpc;

    for (int k = 0; k < 64; k++) mem[k] = 32'(k);

    // reset, start, stream, 3-cycle stall at pc 4, redirect+stall at pc 9
    tbl[0]  = mk(1,0,0,0, 0,  0, 0,  0, IDLE);
    tbl[1]  = mk(0,1,0,0, 0,  0, 0,  1, RUN);
    tbl[2]  = mk(0,0,0,0, 0,  1, 0,  2, RUN);
    tbl[3]  = mk(0,0,0,0, 0,  1, 1,  3, RUN);
    tbl[4]  = mk(0,0,0,0, 0,  1, 2,  4, RUN);
    tbl[5]  = mk(0,0,0,0, 0,  1, 3,  5, RUN);
    tbl[6]  = mk(0,0,0,0, 0,  1, 4,  6, RUN);
    tbl[7]  = mk(0,0,1,0, 0,  1, 4,  6, HELD);
    tbl[8]  = mk(0,0,1,0, 0,  1, 4,  6, HELD);
    tbl[9]  = mk(0,0,1,0, 0,  1, 4,  6, HELD);
    tbl[10] = mk(0,0,0,0, 0,  1, 5,  7, RUN);
    tbl[11] = mk(0,0,0,0, 0,  1, 6,  8, RUN);
    tbl[12] = mk(0,0,0,0, 0,  1, 7,  9, RUN);
    tbl[13] = mk(0,0,0,0, 0,  1, 8, 10, RUN);
    tbl[14] = mk(0,0,0,0, 0,  1, 9, 11, RUN);
    tbl[15] = mk(0,0,1,1, 20, 0, 0, 20, RUN);
    tbl[16] = mk(0,0,0,0, 0,  0, 0, 21, RUN);
    tbl[17] = mk(0,0,0,0, 0,  1, 20, 22, RUN);
    tbl[18] = mk(0,0,0,0, 0,  1, 21, 23, RUN);
    tbl[19] = mk(0,0,0,0, 0,  1, 22, 24, RUN);

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].sl, tbl[i].rd, tbl[i].ra);
      chk($sformatf("tbl%0d_valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].ev});
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i), {26'd0, inst_pc}, {26'd0, tbl[i].epc});
        chk($sformatf("tbl%0d_out", i), inst_out, {26'd0, tbl[i].epc});
      end else begin
        chk($sformatf("tbl%0d_out", i), inst_out, NOP);
      end
      chk($sformatf("tbl%0d_addr", i), {26'd0, imem_addr}, {26'd0, tbl[i].eaddr});
      chk($sformatf("tbl%0d_state", i), {30'd0, dbg_state}, {30'd0, IDLE_to_bits(tbl[i].est)});
    end

    // boot vector: redirect in IDLE then start
    step(1,0,0,0,0);
    step(0,0,0,1,40);
    chk("boot_state", {30'd0, dbg_state}, {30'd0, IDLE_to_bits(IDLE)});
    chk("boot_addr", {26'd0, imem_addr}, 32'd40);
    step(0,1,0,0,0);
    chk("boot_valid0", {31'd0, inst_valid}, 32'd0);
    step(0,0,0,0,0);
    chk("boot_valid1", {31'd0, inst_valid}, 32'd1);
    chk("boot_pc", {26'd0, inst_pc}, 32'd40);

    // wrap: redirect to 62 while running -> 62, 63, 0, 1
    step(0,0,0,1,62);
    step(0,0,0,0,0);
    chk("wrap_gap", {31'd0, inst_valid}, 32'd0);
    wpc = 6'd62;
    for (int k = 0; k < 4; k++) begin
      step(0,0,0,0,0);
      chk($sformatf("wrap_pc%0d", k), {26'd0, inst_pc}, {26'd0, wpc});
      chk($sformatf("wrap_out%0d", k), inst_out, {26'd0, wpc});
      wpc = wpc + 1'b1;
    end

    // reset while HELD with a parked word, alongside start/redirect
    step(0,0,1,0,0);
    step(0,0,1,0,0);
    chk("held_state", {30'd0, dbg_state}, {30'd0, IDLE_to_bits(HELD)});
    step(1,1,1,1,33);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_out", inst_out, NOP);
    chk("rst_addr", {26'd0, imem_addr}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, IDLE_to_bits(IDLE)});
    step(0,0,0,0,0);
    chk("rst_no_leak", {31'd0, inst_valid}, 32'd0);

    // random traffic against the model
    for (int k = 0; k < 64; k++) mem[k] = $urandom;
    step(1,0,0,0,0);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0,79) == 0,
           $urandom_range(0,5) == 0,
           $urandom_range(0,2) == 0,
           $urandom_range(0,13) == 0,
           AW'($urandom_range(0,63)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  function automatic logic [1:0] IDLE_to_bits(fetch_state_t s);
    return s;
  endfunction
endmodule
